// File: rtl/cdb_pkg.sv
// Shared CDB definitions: widths, requester indices, arbiter state encoding and
// the broadcast bus layout consumed by the ROB and reservation stations.
package cdb_pkg;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_MUL  = 1;
  localparam int REQ_LDST = 2;
  localparam int REQ_BR   = 3;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } cdb_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              branch;
    logic              branch_taken;
  } cdb_bus;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating-priority one-hot picker: the first valid requester at or above
// rr_ptr (wrapping modulo NUM_REQ) wins.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a registered broadcast and a flush-hold window
// that blocks grants after a taken branch or an external flush.
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = cdb_pkg::TAG_W,
  parameter int DATA_W     = cdb_pkg::DATA_W,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_branch,
  input  logic [NUM_REQ-1:0]        req_branch_taken,
  input  logic                      flush,
  output logic                      Cdb_valid,
  output logic [TAG_W-1:0]          Cdb_rd_tag,
  output logic [DATA_W-1:0]         Cdb_data,
  output logic                      Cdb_branch,
  output logic                      Cdb_branch_taken,
  output logic                      hold_active
);
  import cdb_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(FLUSH_HOLD + 1);

  cdb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]    cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]   cdb_data_q, cdb_data_d;
  logic                cdb_br_q, cdb_br_d;
  logic                cdb_tk_q, cdb_tk_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [NUM_REQ-1:0]  accept;
  logic                any_acc;
  logic [PTR_W-1:0]    win_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt       (pick_gnt)
  );

  // Ready depends only on state, flush and the request vector, never on Cdb_*.
  always_comb begin
    req_ready = '0;
    if (state_q == ARB && !flush) req_ready = pick_gnt;
    accept  = req_valid & req_ready;
    any_acc = |accept;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (accept[k]) win_idx = PTR_W'(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    cdb_valid_d = any_acc;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_br_d    = cdb_br_q;
    cdb_tk_d    = cdb_tk_q;

    if (any_acc) begin
      cdb_tag_d  = req_tag[int'(win_idx)*TAG_W +: TAG_W];
      cdb_data_d = req_data[int'(win_idx)*DATA_W +: DATA_W];
      cdb_br_d   = req_branch[win_idx];
      cdb_tk_d   = req_branch_taken[win_idx];
      rr_ptr_d   = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
    end

    case (state_q)
      ARB: begin
        if (flush || (any_acc && req_branch_taken[win_idx])) begin
          state_d    = HOLD;
          hold_cnt_d = CNT_W'(FLUSH_HOLD);
        end
      end
      HOLD: begin
        // Leaving on count 1 keeps grants blocked for exactly FLUSH_HOLD cycles.
        if (flush) begin
          hold_cnt_d = CNT_W'(FLUSH_HOLD);
        end else if (hold_cnt_q == CNT_W'(1)) begin
          state_d    = ARB;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d    = ARB;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_br_q    <= 1'b0;
      cdb_tk_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_br_q    <= cdb_br_d;
      cdb_tk_q    <= cdb_tk_d;
    end
  end

  assign Cdb_valid        = cdb_valid_q;
  assign Cdb_rd_tag       = cdb_tag_q;
  assign Cdb_data         = cdb_data_q;
  assign Cdb_branch       = cdb_br_q;
  assign Cdb_branch_taken = cdb_tk_q;
  assign hold_active      = (state_q == HOLD);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-cycle vector table with a broadcast
// scoreboard, plus a hand-written asynchronous reset during HOLD.
module tb_cdb_arbiter;

  localparam int NREQ = 4;
  localparam int TW   = 5;
  localparam int DW   = 32;
  localparam int BW   = 1 + TW + DW + 1 + 1;

  logic                 clock;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*TW-1:0]   req_tag;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_branch;
  logic [NREQ-1:0]      req_branch_taken;
  logic                 flush;
  logic                 Cdb_valid;
  logic [TW-1:0]        Cdb_rd_tag;
  logic [DW-1:0]        Cdb_data;
  logic                 Cdb_branch;
  logic                 Cdb_branch_taken;
  logic                 hold_active;

  cdb_arbiter #(.NUM_REQ(NREQ), .TAG_W(TW), .DATA_W(DW), .FLUSH_HOLD(2)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_tag          (req_tag),
    .req_data         (req_data),
    .req_branch       (req_branch),
    .req_branch_taken (req_branch_taken),
    .flush            (flush),
    .Cdb_valid        (Cdb_valid),
    .Cdb_rd_tag       (Cdb_rd_tag),
    .Cdb_data         (Cdb_data),
    .Cdb_branch       (Cdb_branch),
    .Cdb_branch_taken (Cdb_branch_taken),
    .hold_active      (hold_active)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       flush;
    logic [3:0] br;
    logic [3:0] tk;
    logic [3:0] exp_ready;
    logic       exp_hold;
  } vec_t;

  vec_t            vecs[$];
  logic [BW-1:0]   exp_q[$];
  logic [TW-1:0]   tag_tab[NREQ];
  logic [DW-1:0]   data_tab[NREQ];
  int              total;
  int              bad;

  function automatic vec_t mk(logic rst, logic [3:0] valid, logic fl, logic [3:0] br,
                              logic [3:0] tk, logic [3:0] exp_ready, logic exp_hold);
    vec_t v;
    v.rst = rst; v.valid = valid; v.flush = fl; v.br = br; v.tk = tk;
    v.exp_ready = exp_ready; v.exp_hold = exp_hold;
    return v;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    req_valid = '0; flush = 1'b0; req_branch = '0; req_branch_taken = '0;
    reset_n = 1'b0;
    #2;
    check("rst_cdb_valid", BW'(Cdb_valid), '0);
    check("rst_cdb_tag", BW'(Cdb_rd_tag), '0);
    check("rst_cdb_data", BW'(Cdb_data), '0);
    check("rst_cdb_br", BW'({Cdb_branch, Cdb_branch_taken}), '0);
    check("rst_hold", BW'(hold_active), '0);
    check("rst_ready", BW'(req_ready), '0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  // driver: one cycle of stimulus, same-cycle ready check, next-cycle broadcast check
  task automatic apply_cycle(input vec_t v);
    logic [BW-1:0] e;
    logic [BW-1:0] got;
    int g;
    req_valid = v.valid; flush = v.flush;
    req_branch = v.br; req_branch_taken = v.tk;
    #3;
    check("req_ready", BW'(req_ready), BW'(v.exp_ready));
    check("hold_active", BW'(hold_active), BW'(v.exp_hold));
    g = -1;
    for (int i = 0; i < NREQ; i++) if (v.exp_ready[i]) g = i;
    if (g >= 0) e = {1'b1, tag_tab[g], data_tab[g], v.br[g], v.tk[g]};
    else        e = '0;
    exp_q.push_back(e);
    @(posedge clock); #1;
    e = exp_q.pop_front();
    got = {Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken};
    if (e[BW-1]) check("cdb_bus", got, e);
    else         check("cdb_valid_low", BW'(Cdb_valid), '0);
  endtask

  initial begin
    total = 0; bad = 0;
    tag_tab  = '{5'd1, 5'd2, 5'd7, 5'd4};
    data_tab = '{32'h0000_00A0, 32'h0000_00B1, 32'h0000_1234, 32'h0000_00D3};
    for (int i = 0; i < NREQ; i++) begin
      req_tag[i*TW +: TW]  = tag_tab[i];
      req_data[i*DW +: DW] = data_tab[i];
    end
    reset_n = 1'b1;
    req_valid = '0; flush = 1'b0; req_branch = '0; req_branch_taken = '0;
    @(posedge clock); #1;

    //                rst valid    fl  br       tk       ready    hold
    // single request from reset, then idle
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    // fairness: all valid from reset -> 0,1,2,3,0
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0001, 0));
    // taken branch on unit 3 with units 0/1 waiting: two blocked cycles, then unit 0
    vecs.push_back(mk(1, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b1011, 0, 4'b1000, 4'b1000, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b0011, 0, 4'b0000, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 4'b0000, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 4'b0000, 4'b0000, 4'b0001, 0));
    // not-taken branch: no hold, next request granted immediately
    vecs.push_back(mk(0, 4'b1000, 0, 4'b1000, 4'b0000, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0010, 0));
    // external flush blocks a grant, then restarts the hold count mid-HOLD
    vecs.push_back(mk(0, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      apply_cycle(vecs[i]);
    end

    // asynchronous reset while in HOLD
    apply_cycle(mk(0, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 0));
    check("mid_hold_entered", BW'(hold_active), BW'(1));
    req_valid = '0; req_branch = '0; req_branch_taken = '0;
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_hold_rst_hold", BW'(hold_active), '0);
    check("mid_hold_rst_valid", BW'(Cdb_valid), '0);
    check("mid_hold_rst_tag", BW'(Cdb_rd_tag), '0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_q.delete();
    apply_cycle(mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0001, 0));
    apply_cycle(mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0010, 0));

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin scheduler for the common data bus (CDB) feeding the ROB's `Cdb_*` inputs. It accepts completion results from up to `NUM_REQ` functional units over valid/ready handshakes and grants one per cycle. The winner is driven onto a registered CDB broadcast. After broadcasting a taken branch it enforces a flush-hold window so the ROB, RST and order queue finish their flush before new results arrive.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesting units (index 0 = ALU, 1 = MUL, 2 = LD/ST, 3 = BRANCH).
- `TAG_W`, default 5: ROB tag width.
- `DATA_W`, default 32: result data width.
- `FLUSH_HOLD`, default 2: number of grant-blocked cycles following a taken-branch broadcast.

Ports:
- `clock` in 1: single clock; all state on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: unit i has a result pending.
- `req_ready` out NUM_REQ: combinational one-hot grant. Unit i's result is accepted this cycle when `req_valid[i] && req_ready[i]`.
- `req_tag` in NUM_REQ*TAG_W: per-unit ROB tag, unit i in slice [i*TAG_W +: TAG_W].
- `req_data` in NUM_REQ*DATA_W: per-unit result, same slicing.
- `req_branch` in NUM_REQ: per-unit flag, result is a branch.
- `req_branch_taken` in NUM_REQ: per-unit flag, branch must be taken (mispredicted).
- `flush` in 1: external flush request.
- `Cdb_valid` out 1: registered broadcast valid.
- `Cdb_rd_tag` out TAG_W: registered broadcast tag.
- `Cdb_data` out DATA_W: registered broadcast data.
- `Cdb_branch` out 1: registered broadcast branch flag.
- `Cdb_branch_taken` out 1: registered broadcast taken flag.
- `hold_active` out 1: high while in the HOLD state.

## Operation
- **States.**
  - ARB: grants allowed.
  - HOLD: grants blocked; `hold_cnt` counts down.
- **Arbitration (ARB only).**
  - Rotating pointer `rr_ptr` (log2 NUM_REQ bits) marks the highest-priority requester.
  - Winner is the first i with `req_valid[i]`, searching from `rr_ptr` upward modulo NUM_REQ.
  - `req_ready` is one-hot on the winner. It is all-zero when no request is valid, in HOLD, or when `flush` = 1.
- **Pointer update.** On an accepted grant to unit i, `rr_ptr <= (i+1) mod NUM_REQ`. The pointer does not change when nothing is accepted.
- **Broadcast register.**
  - On a grant, the winner's tag, data, branch and taken flags are loaded and `Cdb_valid <= 1`.
  - With no grant, `Cdb_valid <= 0`. The payload registers hold their last value.
- **ARB -> HOLD.**
  - Trigger: an accepted grant whose `req_branch_taken` = 1, or `flush` = 1.
  - On entry, `hold_cnt <= FLUSH_HOLD`.
- **HOLD.**
  - `hold_cnt` decrements each cycle.
  - HOLD -> ARB on the cycle `hold_cnt` = 1 (blocked for exactly FLUSH_HOLD cycles).
  - `flush` = 1 during HOLD reloads `hold_cnt` to FLUSH_HOLD.
- **Flush precedence.**
  - `flush` forces `req_ready` = 0 in that cycle.
  - It also clears `Cdb_valid` on the next edge, overriding any grant.
- **Branch results with `req_branch_taken` = 0** are ordinary broadcasts and do not enter HOLD.
- **FLUSH_HOLD = 0** is illegal; the minimum is 1.

## Timing
- **Reset values** (`reset_n` = 0, asynchronous):
  - Outputs: `Cdb_valid` = 0, `Cdb_rd_tag` = 0, `Cdb_data` = 0, `Cdb_branch` = 0, `Cdb_branch_taken` = 0, `hold_active` = 0, `req_ready` = 0.
  - Internal: state = ARB, `rr_ptr` = 0, `hold_cnt` = 0.
- **Latency:** accepted in cycle N -> `Cdb_*` valid in cycle N+1, for exactly one cycle.
- **Throughput:** one broadcast per cycle in ARB.
- **Handshake:** a unit holds its valid and payload stable until it sees ready. Ready has no combinational dependence on `Cdb_*`.
- **Taken branch accepted in cycle N:**
  - Broadcast in N+1.
  - `hold_active` = 1 and `req_ready` = 0 in N+1 .. N+FLUSH_HOLD.
  - Grants resume in N+FLUSH_HOLD+1.
- **Reset mid-HOLD:** returns immediately to ARB with all outputs cleared.

## Structure
- **Shared package** `cdb_pkg`:
  - `TAG_W`, `DATA_W`.
  - Requester index constants `REQ_ALU`, `REQ_MUL`, `REQ_LDST`, `REQ_BR`.
  - State encoding `ARB`, `HOLD`.
  - A `cdb_bus` packed struct {valid, tag, data, branch, branch_taken}; reused by the ROB and reservation stations.
- **Sub-module** `rr_pick`: combinational rotating-priority one-hot picker (inputs: `req_valid`, `rr_ptr`; output: one-hot grant). The FSM, counter and broadcast register stay in `cdb_arbiter`.

## Test plan
- **Reset and single request:**
  - Stimulus: reset, then unit 2 valid with tag 7, data 0x1234.
  - Required: `req_ready` = 0100 in the same cycle; next cycle `Cdb_valid` = 1, `Cdb_rd_tag` = 7, `Cdb_data` = 0x1234.
  - Following cycle: `Cdb_valid` = 0.
- **Fairness:**
  - Stimulus: all 4 units valid continuously from reset.
  - Required: grant order 0, 1, 2, 3, 0; four broadcasts in four consecutive cycles.
- **Taken-branch hold** (FLUSH_HOLD = 2):
  - Stimulus: unit 3 branch taken, tag 4, with units 0 and 1 also valid.
  - Required: broadcast tag 4 with `Cdb_branch_taken` = 1; `req_ready` = 0 and `hold_active` = 1 for the next 2 cycles; then unit 0 granted.
- **External flush overrides a grant:**
  - Stimulus: `flush` = 1 in the same cycle unit 0 is valid.
  - Required: `req_ready` = 0000, `Cdb_valid` = 0 next cycle, HOLD entered; `flush` during HOLD restarts the count.
- **Not-taken branch:**
  - Stimulus: unit 3 with `req_branch` = 1, `req_branch_taken` = 0.
  - Required: `Cdb_branch` = 1, `Cdb_branch_taken` = 0; no HOLD; the next request is granted the following cycle.
- **Reset mid-HOLD:**
  - Stimulus: assert `reset_n` = 0 asynchronously during HOLD.
  - Required: `hold_active` and `Cdb_valid` drop immediately; after release, unit 0 has priority.
